// File: rtl/pc_fetch_reg_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_reg_if
// Instruction-memory request channel used by pc_fetch_reg.
//   req   : request valid (fetch unit -> memory)
//   addr  : request address, stable while req=1 until the handshake
//   ready : memory accepts/completes the request this cycle
// A transfer completes on a rising clock edge where req && ready.
// -----------------------------------------------------------------------------
interface pc_fetch_reg_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] addr;
  logic             ready;

  // Fetch unit side.
  modport master (output req, output addr, input ready);
  // Instruction-memory side.
  modport slave  (input req, input addr, output ready);
endinterface

// File: rtl/pc_fetch_reg.sv
// -----------------------------------------------------------------------------
// pc_fetch_reg
// Program-counter register and next-PC selector, upstream of pcAdder.
//
// Ports:
//   clk             : system clock, rising edge
//   rst_n           : asynchronous active-low reset
//   pc              : current PC, feeds pcAdder
//   pc_plus4        : pcAdder result (pc+4), the sequential next PC
//   stall           : hold PC and start no new request
//   redirect_valid  : branch/jump taken this cycle
//   redirect_target : redirect destination (low two bits forced to 00)
//   imem            : instruction-memory request channel (master side)
//   fetch_valid     : one-cycle pulse for each non-squashed completed fetch
//   fetch_pc        : PC of the completed fetch
//   misalign        : sticky flag, a redirect target was not word-aligned
// -----------------------------------------------------------------------------
module pc_fetch_reg #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WIDTH-1:0]     pc,
  input  logic [WIDTH-1:0]     pc_plus4,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WIDTH-1:0]     redirect_target,
  pc_fetch_reg_if.master       imem,
  output logic                 fetch_valid,
  output logic [WIDTH-1:0]     fetch_pc,
  output logic                 misalign
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    REQ_SQUASH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic             misalign_q, misalign_d;

  logic             req;
  logic             handshake;
  logic [WIDTH-1:0] target_aligned;

  // Request is purely a function of state and stall. Once a request has been
  // squashed it must still complete, so stall is ignored in REQ_SQUASH.
  assign req            = (state_q == REQ) ? !stall : (state_q == REQ_SQUASH);
  assign handshake      = req && imem.ready;
  assign target_aligned = {redirect_target[WIDTH-1:2], 2'b00};

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    fetch_valid_d = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    misalign_d    = misalign_q;

    unique case (state_q)
      IDLE: begin
        // One quiet cycle after reset before the first request.
        state_d = REQ;
      end

      REQ: begin
        if (redirect_valid) begin
          if (redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
          if (handshake) begin
            // The fetch completing now is down the wrong path: drop it.
            pc_d = target_aligned;
          end else begin
            pending_d = target_aligned;
            if (req) state_d = REQ_SQUASH;   // address must stay stable
            else     pc_d    = target_aligned;  // nothing in flight
          end
        end else if (handshake) begin
          fetch_valid_d = 1'b1;
          fetch_pc_d    = pc_q;
          pc_d          = pc_plus4;
        end
      end

      REQ_SQUASH: begin
        if (redirect_valid) begin
          if (redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
          pending_d = target_aligned;
        end
        if (handshake) begin
          // Last redirect wins, including one arriving on the handshake edge.
          pc_d    = redirect_valid ? target_aligned : pending_q;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      pending_q     <= '0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc          = pc_q;
  assign imem.req    = req;
  assign imem.addr   = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_reg.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_reg
// Directed testbench for pc_fetch_reg. pcAdder is modelled as pc+4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_reg;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             fetch_valid;
  logic [WIDTH-1:0] fetch_pc;
  logic             misalign;

  int total = 0;
  int bad   = 0;

  pc_fetch_reg_if #(.WIDTH(WIDTH)) imem ();

  pc_fetch_reg #(.WIDTH(WIDTH), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (imem),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .misalign        (misalign)
  );

  // pcAdder stand-in.
  assign pc_plus4 = pc + 32'd4;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_pulse(input logic [WIDTH-1:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    step();
    redirect_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; imem.ready = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem.req); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL reset_fpc: got %h want 0", fetch_pc); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_mis: got %b want 0", misalign); end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", imem.req); end
  endtask

  task automatic test_back_to_back();
    imem.ready = 1'b1;
    step();  // IDLE -> REQ, pc unchanged
    total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL b2b_first_req: got %b want 1", imem.req); end
    total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL b2b_first_addr: got %h want 0", imem.addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL b2b_first_fv: got %b want 0", fetch_valid); end
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (imem.addr !== 32'(4 * k)) begin bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, imem.addr, 32'(4 * k)); end
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL b2b_fv[%0d]: got %b want 1", k, fetch_valid); end
      total++; if (fetch_pc !== 32'(4 * (k - 1))) begin bad++; $display("FAIL b2b_fpc[%0d]: got %h want %h", k, fetch_pc, 32'(4 * (k - 1))); end
    end
    imem.ready = 1'b0;
  endtask

  task automatic test_wait_state();
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL wait_req[%0d]: got %b want 1", k, imem.req); end
      total++; if (imem.addr !== 32'h10) begin bad++; $display("FAIL wait_addr[%0d]: got %h want 10", k, imem.addr); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL wait_fv[%0d]: got %b want 0", k, fetch_valid); end
    end
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL wait_done_fv: got %b want 1", fetch_valid); end
    total++; if (fetch_pc !== 32'h10) begin bad++; $display("FAIL wait_done_fpc: got %h want 10", fetch_pc); end
    total++; if (imem.addr !== 32'h14) begin bad++; $display("FAIL wait_done_addr: got %h want 14", imem.addr); end
  endtask

  task automatic test_redirect_squash();
    imem.ready = 1'b1;
    repeat (3) step();  // 0x14 -> 0x20
    imem.ready = 1'b0;
    total++; if (imem.addr !== 32'h20) begin bad++; $display("FAIL sq_start_addr: got %h want 20", imem.addr); end
    redirect_pulse(32'h100);
    total++; if (imem.addr !== 32'h20) begin bad++; $display("FAIL sq_hold_addr0: got %h want 20", imem.addr); end
    total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL sq_req: got %b want 1", imem.req); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL sq_fv0: got %b want 0", fetch_valid); end
    step();
    total++; if (imem.addr !== 32'h20) begin bad++; $display("FAIL sq_hold_addr1: got %h want 20", imem.addr); end
    imem.ready = 1'b1;
    step();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL sq_done_fv: got %b want 0", fetch_valid); end
    total++; if (imem.addr !== 32'h100) begin bad++; $display("FAIL sq_done_addr: got %h want 100", imem.addr); end
    // Redirect on the same edge as a handshake: that fetch is dropped.
    redirect_pulse(32'h300);
    imem.ready = 1'b0;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rhs_fv: got %b want 0", fetch_valid); end
    total++; if (imem.addr !== 32'h300) begin bad++; $display("FAIL rhs_addr: got %h want 300", imem.addr); end
  endtask

  task automatic test_last_wins_misalign();
    redirect_pulse(32'h40);
    stall = 1'b1;
    #1;
    total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL sq_stall_req: got %b want 1", imem.req); end
    stall = 1'b0;
    redirect_pulse(32'h80);
    total++; if (imem.addr !== 32'h300) begin bad++; $display("FAIL lw_hold_addr: got %h want 300", imem.addr); end
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    total++; if (imem.addr !== 32'h80) begin bad++; $display("FAIL lw_addr: got %h want 80", imem.addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL lw_fv: got %b want 0", fetch_valid); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_before: got %b want 0", misalign); end
    redirect_pulse(32'h203);
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    total++; if (imem.addr !== 32'h200) begin bad++; $display("FAIL mis_addr: got %h want 200", imem.addr); end
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_set: got %b want 1", misalign); end
    repeat (2) step();
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky: got %b want 1", misalign); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", imem.req); end
    redirect_pulse(32'h30);  // stalled: loads pc directly
    total++; if (pc !== 32'h30) begin bad++; $display("FAIL stall_redir_pc: got %h want 30", pc); end
    imem.ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL stall_hold_req[%0d]: got %b want 0", k, imem.req); end
      total++; if (pc !== 32'h30) begin bad++; $display("FAIL stall_hold_pc[%0d]: got %h want 30", k, pc); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL stall_hold_fv[%0d]: got %b want 0", k, fetch_valid); end
    end
    redirect_pulse(32'h60);
    total++; if (pc !== 32'h60) begin bad++; $display("FAIL stall_redir2_pc: got %h want 60", pc); end
    stall = 1'b0;
    #1;
    total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL unstall_req: got %b want 1", imem.req); end
    step();
    imem.ready = 1'b0;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL unstall_fv: got %b want 1", fetch_valid); end
    total++; if (fetch_pc !== 32'h60) begin bad++; $display("FAIL unstall_fpc: got %h want 60", fetch_pc); end
    total++; if (imem.addr !== 32'h64) begin bad++; $display("FAIL unstall_addr: got %h want 64", imem.addr); end
  endtask

  task automatic test_wrap();
    stall = 1'b1;
    redirect_pulse(32'hFFFF_FFFC);
    stall = 1'b0;
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 0", imem.addr); end
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL wrap_fv: got %b want 1", fetch_valid); end
    total++; if (fetch_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fpc: got %h want fffffffc", fetch_pc); end
  endtask

  task automatic test_reset_mid_request();
    stall = 1'b1;
    redirect_pulse(32'h44);
    stall = 1'b0;
    #1;
    total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL rm_req_before: got %b want 1", imem.req); end
    total++; if (imem.addr !== 32'h44) begin bad++; $display("FAIL rm_addr_before: got %h want 44", imem.addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL rm_req: got %b want 0", imem.req); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rm_pc: got %h want 0", pc); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rm_fv: got %b want 0", fetch_valid); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rm_mis: got %b want 0", misalign); end
    step();
    rst_n = 1'b1;
    imem.ready = 1'b1;
    step();  // IDLE -> REQ
    total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL rm_resume_req: got %b want 1", imem.req); end
    total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL rm_resume_addr: got %h want 0", imem.addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rm_resume_fv: got %b want 0", fetch_valid); end
    step();
    imem.ready = 1'b0;
    total++; if (imem.addr !== 32'h4) begin bad++; $display("FAIL rm_next_addr: got %h want 4", imem.addr); end
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL rm_next_fv: got %b want 1", fetch_valid); end
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL rm_next_fpc: got %h want 0", fetch_pc); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_state();
    test_redirect_squash();
    test_last_wins_misalign();
    test_stall();
    test_wrap();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
